// File: rtl/tx_fifo_sched_if.sv
// Byte-write / UART-handshake bundle for tx_fifo_sched.
// master = producer/UART side, slave = the scheduler.
interface tx_fifo_sched_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_ADDR = 4
);
    logic               i_wr;
    logic [NB_DATA-1:0] i_data;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_full;
    logic               o_empty;
    logic [NB_ADDR:0]   o_count;
    logic               o_overflow;

    modport master (
        output i_wr, i_data, i_tx_done,
        input  o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow
    );

    modport slave (
        input  i_wr, i_data, i_tx_done,
        output o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow
    );
endinterface

// File: rtl/tx_fifo_sched.sv
// Byte FIFO plus one-start-per-byte UART transmit scheduler.
// Optional sticky drop flag enabled by defining TX_FIFO_OVERFLOW_EN.
module tx_fifo_sched #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_ADDR = 4
) (
    input logic           i_clk,
    input logic           i_reset,
    tx_fifo_sched_if.slave bus
);
    localparam int unsigned DEPTH  = 2 ** NB_ADDR;
    localparam int unsigned NB_CNT = NB_ADDR + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1
    } state_e;

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   mem_q [DEPTH];
    logic [NB_DATA-1:0]   mem_d [DEPTH];
    logic [NB_ADDR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NB_CNT-1:0]    count_q, count_d;
    logic                 tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 full;
    logic                 pop;
    logic                 wr_en;

    // Storage, pointer/count update and scheduler next state
    always_comb begin
        full       = (count_q == NB_CNT'(DEPTH));
        pop        = (state_q == ST_WAIT) && bus.i_tx_done;
        wr_en      = bus.i_wr && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = bus.i_data;
            wr_ptr_d        = wr_ptr_q + NB_ADDR'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + NB_ADDR'(1);
        end
        count_d = count_q + NB_CNT'(wr_en) - NB_CNT'(pop);

        case (state_q)
            ST_IDLE: begin
                // Decision uses registered count so a fresh write never bypasses storage
                if (count_q != '0) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Byte RAM needs no reset: entries are only read once counted valid
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

`ifdef TX_FIFO_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (bus.i_wr & full & ~pop);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_overflow = overflow_q;
`else
    assign bus.o_overflow = 1'b0;
`endif

    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_count    = count_q;
    assign bus.o_full     = full;
    assign bus.o_empty    = (count_q == '0);
endmodule

// File: tb/tb_tx_fifo_sched.sv
// Self-checking bench for tx_fifo_sched: directed scenarios plus a
// randomized run against a queue-based transaction model.
module tb_tx_fifo_sched;
    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_ADDR = 4;
    localparam int unsigned DEPTH   = 16;

`ifdef TX_FIFO_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset;

    tx_fifo_sched_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus_if ();

    tx_fifo_sched #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus_if)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] mon_q [$];
    bit prev_start = 1'b0;

    // Record every start pulse just after the edge; a pulse wider than one cycle is an error
    always @(posedge i_clk) begin
        #1;
        if (bus_if.o_tx_start === 1'b1) begin
            mon_q.push_back(bus_if.o_tx_data);
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL start_width: o_tx_start high two cycles running at %0t", $time);
            end
        end
        prev_start = (bus_if.o_tx_start === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset          = 1'b1;
        bus_if.i_wr      = 1'b0;
        bus_if.i_data    = '0;
        bus_if.i_tx_done = 1'b0;
        mon_q.delete();
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus_if.i_wr   = 1'b1;
        bus_if.i_data = b;
        step();
        bus_if.i_wr   = 1'b0;
    endtask

    task automatic pulse_done();
        bus_if.i_tx_done = 1'b1;
        step();
        bus_if.i_tx_done = 1'b0;
    endtask

    // Acknowledge n transmissions, waiting for start number first_idx+k each time
    task automatic drain(input int first_idx, input int n, output int timeouts);
        timeouts = 0;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (mon_q.size() <= first_idx + k && t < 200) begin
                step();
                t++;
            end
            if (mon_q.size() <= first_idx + k) begin
                timeouts++;
                return;
            end
            pulse_done();
        end
    endtask

    task automatic test_reset();
        i_reset          = 1'b1;
        bus_if.i_wr      = 1'b0;
        bus_if.i_data    = '0;
        bus_if.i_tx_done = 1'b0;
        #1;
        checks++;
        if (bus_if.o_tx_start !== 1'b0 || bus_if.o_tx_data !== 8'h00 || bus_if.o_empty !== 1'b1 ||
            bus_if.o_full !== 1'b0 || bus_if.o_count !== 5'd0 || bus_if.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: start=%b data=%h empty=%b full=%b count=%0d ovf=%b, need 0 00 1 0 0 0",
                     bus_if.o_tx_start, bus_if.o_tx_data, bus_if.o_empty, bus_if.o_full,
                     bus_if.o_count, bus_if.o_overflow);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        step(3);
        checks++;
        if (bus_if.o_tx_start !== 1'b0 || bus_if.o_count !== 5'd0) begin
            errors++;
            $display("FAIL idle_after_reset: start=%b count=%0d, need 0 0", bus_if.o_tx_start, bus_if.o_count);
        end
    endtask

    task automatic test_single();
        int bad = 0;
        do_reset();
        write_byte(8'h5A);
        checks++;
        if (bus_if.o_count !== 5'd1 || bus_if.o_tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_stored: count=%0d start=%b, need 1 0", bus_if.o_count, bus_if.o_tx_start);
        end
        step();
        checks++;
        if (bus_if.o_tx_start !== 1'b1 || bus_if.o_tx_data !== 8'h5A) begin
            errors++;
            $display("FAIL single_start: start=%b data=%h, need 1 5a", bus_if.o_tx_start, bus_if.o_tx_data);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus_if.o_tx_start !== 1'b0 || bus_if.o_tx_data !== 8'h5A) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_hold: %0d bad cycles while waiting, need 0", bad);
        end
        pulse_done();
        checks++;
        if (bus_if.o_empty !== 1'b1 || bus_if.o_count !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: empty=%b count=%0d, need 1 0", bus_if.o_empty, bus_if.o_count);
        end
        step(3);
        checks++;
        if (mon_q.size() != 1) begin
            errors++;
            $display("FAIL single_once: %0d starts, need 1", mon_q.size());
        end
    endtask

    task automatic test_burst();
        do_reset();
        bus_if.i_wr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus_if.i_data = 8'(i);
            step();
        end
        bus_if.i_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int t = 0;
            while (mon_q.size() <= i && t < 50) begin
                step();
                t++;
            end
            if (i > 0) begin
                checks++;
                if (t != 1) begin
                    errors++;
                    $display("FAIL burst_gap%0d: start %0d cycles after done, need 1", i, t);
                end
            end
            checks++;
            if (mon_q.size() <= i || mon_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL burst_data%0d: got %h, need %h", i,
                         (mon_q.size() > i) ? mon_q[i] : 8'hxx, 8'(i + 1));
            end
            step(9);
            pulse_done();
        end
        step(5);
        checks++;
        if (mon_q.size() != 3 || bus_if.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL burst_total: %0d starts empty=%b, need 3 1", mon_q.size(), bus_if.o_empty);
        end
    endtask

    task automatic test_full_overflow();
        int to;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i));
        checks++;
        if (bus_if.o_full !== 1'b1 || bus_if.o_count !== 5'd16 || bus_if.o_empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flag: full=%b count=%0d empty=%b, need 1 16 0",
                     bus_if.o_full, bus_if.o_count, bus_if.o_empty);
        end
        write_byte(8'hFF);
        checks++;
        if (bus_if.o_count !== 5'd16 || bus_if.o_overflow !== OVF_EN) begin
            errors++;
            $display("FAIL full_drop: count=%0d ovf=%b, need 16 %b", bus_if.o_count, bus_if.o_overflow, OVF_EN);
        end
        drain(0, 16, to);
        step(5);
        checks++;
        if (to != 0 || mon_q.size() != 16) begin
            errors++;
            $display("FAIL full_drain_len: %0d starts timeouts=%0d, need 16 0", mon_q.size(), to);
        end
        for (int i = 0; i < mon_q.size(); i++) if (mon_q[i] !== 8'h10 + 8'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_drain_order: %0d wrong bytes, need 0", bad);
        end
        checks++;
        if (bus_if.o_empty !== 1'b1 || bus_if.o_overflow !== OVF_EN) begin
            errors++;
            $display("FAIL full_after: empty=%b ovf=%b, need 1 %b", bus_if.o_empty, bus_if.o_overflow, OVF_EN);
        end
    endtask

    task automatic test_full_simul();
        int to;
        int bad = 0;
        logic [7:0] exp_q [$];
        do_reset();
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i));
        checks++;
        if (bus_if.o_overflow !== 1'b0 || bus_if.o_full !== 1'b1) begin
            errors++;
            $display("FAIL simul_pre: ovf=%b full=%b, need 0 1", bus_if.o_overflow, bus_if.o_full);
        end
        bus_if.i_wr      = 1'b1;
        bus_if.i_data    = 8'hAA;
        bus_if.i_tx_done = 1'b1;
        step();
        bus_if.i_wr      = 1'b0;
        bus_if.i_tx_done = 1'b0;
        checks++;
        if (bus_if.o_count !== 5'd16 || bus_if.o_overflow !== 1'b0 || bus_if.o_full !== 1'b1) begin
            errors++;
            $display("FAIL simul_accept: count=%0d ovf=%b full=%b, need 16 0 1",
                     bus_if.o_count, bus_if.o_overflow, bus_if.o_full);
        end
        drain(1, 16, to);
        step(5);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
        exp_q.push_back(8'hAA);
        checks++;
        if (to != 0 || mon_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL simul_len: %0d starts timeouts=%0d, need 17 0", mon_q.size(), to);
        end
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) if (mon_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL simul_order: %0d wrong bytes, last got %h need aa", bad, mon_q[mon_q.size()-1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
        step();
        checks++;
        if (bus_if.o_count !== 5'd5 || bus_if.o_tx_data !== 8'h30) begin
            errors++;
            $display("FAIL midrst_pre: count=%0d data=%h, need 5 30", bus_if.o_count, bus_if.o_tx_data);
        end
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if (bus_if.o_tx_start !== 1'b0 || bus_if.o_tx_data !== 8'h00 || bus_if.o_count !== 5'd0 ||
            bus_if.o_empty !== 1'b1 || bus_if.o_full !== 1'b0 || bus_if.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: start=%b data=%h count=%0d empty=%b full=%b ovf=%b, need 0 00 0 1 0 0",
                     bus_if.o_tx_start, bus_if.o_tx_data, bus_if.o_count, bus_if.o_empty,
                     bus_if.o_full, bus_if.o_overflow);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        mon_q.delete();
        pulse_done();
        step(5);
        checks++;
        if (mon_q.size() != 0 || bus_if.o_count !== 5'd0 || bus_if.o_empty !== 1'b1) begin
            errors++;
            $display("FAIL midrst_stray_done: starts=%0d count=%0d empty=%b, need 0 0 1",
                     mon_q.size(), bus_if.o_count, bus_if.o_empty);
        end
    endtask

    task automatic test_wrap();
        int to;
        int to_sum = 0;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            write_byte(8'(i));
            drain(i, 1, to);
            to_sum += to;
        end
        step(5);
        checks++;
        if (to_sum != 0 || mon_q.size() != 20) begin
            errors++;
            $display("FAIL wrap_len: %0d starts timeouts=%0d, need 20 0", mon_q.size(), to_sum);
        end
        for (int i = 0; i < mon_q.size(); i++) if (mon_q[i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0 || bus_if.o_count !== 5'd0) begin
            errors++;
            $display("FAIL wrap_order: %0d wrong bytes count=%0d, need 0 0", bad, bus_if.o_count);
        end
    endtask

    // Transaction model: queue holds untransmitted bytes plus the one on the wire
    task automatic test_random();
        logic [7:0] m_q [$];
        bit         m_busy  = 1'b0;
        bit         m_start = 1'b0;
        logic [7:0] m_data  = 8'h00;
        bit         m_ovf   = 1'b0;
        int         prints  = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit         wr, done, pop, start, acc;
            logic [7:0] d;
            int         wr_p, done_p;
            checks++;
            if (bus_if.o_tx_start !== m_start || bus_if.o_tx_data !== m_data ||
                int'(bus_if.o_count) !== m_q.size() || bus_if.o_full !== (m_q.size() == DEPTH) ||
                bus_if.o_empty !== (m_q.size() == 0) || bus_if.o_overflow !== (OVF_EN & m_ovf)) begin
                errors++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL random_cyc%0d: start=%b data=%h count=%0d full=%b empty=%b ovf=%b, need %b %h %0d %b %b %b",
                             cyc, bus_if.o_tx_start, bus_if.o_tx_data, bus_if.o_count, bus_if.o_full,
                             bus_if.o_empty, bus_if.o_overflow, m_start, m_data, m_q.size(),
                             m_q.size() == DEPTH, m_q.size() == 0, OVF_EN & m_ovf);
                end
            end
            wr_p   = (cyc < 300) ? 70 : 25;
            done_p = (cyc < 300) ? 15 : 50;
            wr     = ($urandom_range(99) < wr_p);
            done   = ($urandom_range(99) < done_p);
            d      = 8'($urandom);
            bus_if.i_wr      = wr;
            bus_if.i_data    = d;
            bus_if.i_tx_done = done;

            pop   = m_busy && done;
            start = !m_busy && (m_q.size() != 0);
            acc   = wr && ((m_q.size() < DEPTH) || pop);
            if (wr && !acc) m_ovf = 1'b1;
            m_start = start;
            if (start) begin
                m_data = m_q[0];
                m_busy = 1'b1;
            end
            if (pop) begin
                void'(m_q.pop_front());
                m_busy = 1'b0;
            end
            if (acc) m_q.push_back(d);
            step();
        end
        bus_if.i_wr      = 1'b0;
        bus_if.i_tx_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_overflow();
        test_full_simul();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
